turn_signal_request: RTL and testbench
======================================

# turn_signal_request

Front end of the turn-signal path. It takes the raw left/right stalk contacts and the hazard push-button, synchronizes and debounces them, and resolves them through a state machine into the `leftBlink` / `rightBlink` request levels. The `blinker` output stage consumes those levels. It also owns hazard toggling, stalk-fault detection and optional comfort (lane-change) blinking.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept an input change (10 ms at 50 MHz); must be ≥ 2.
- `TAP_CYCLES`, default 25000000: a stalk hold shorter than this counts as a tap (0.5 s).
- `COMFORT_CYCLES`, default 150000000: comfort-blink duration after a tap (3 s).
- `c50M`  in  1  system clock, 50 MHz.
- `nReset`  in  1  reset, synchronous, active-low.
- `rawLeft`  in  1  left stalk contact, asynchronous, bouncy.
- `rawRight`  in  1  right stalk contact, asynchronous, bouncy.
- `rawHazard`  in  1  hazard push-button, asynchronous, bouncy, momentary.
- `leftBlink`  out  1  left blink request level; registered.
- `rightBlink`  out  1  right blink request level; registered.
- `hazardActive`  out  1  hazard mode on; registered.
- `stalkFault`  out  1  both stalk contacts debounced high; registered.

## Operation
- Each raw input passes through a 2-FF synchronizer, then a debouncer:
  - The counter clears whenever the synchronized value equals the debounced value; otherwise it increments.
  - When the counter reaches `DEBOUNCE_CYCLES-1` with the input still differing, the debounced value takes the new value on the next edge.
- Hazard toggles on each debounced rising edge of `rawHazard`. The falling edge is ignored.
- States (shared enum):
  - `IDLE`
  - `LEFT`, `RIGHT`: stalk held.
  - `LEFT_COMFORT`, `RIGHT_COMFORT`: tap extension.
  - `HAZARD`
  - `FAULT`
- Outputs per state:
  - `LEFT` / `LEFT_COMFORT`: `leftBlink=1`.
  - `RIGHT` / `RIGHT_COMFORT`: `rightBlink=1`.
  - `HAZARD`: both blink outputs =1, `hazardActive=1`.
  - `FAULT`: both blink outputs =0, `stalkFault=1`.
  - All other outputs are 0.
- Transitions, evaluated each cycle on debounced values (`dL`, `dR`). Priority: hazard toggle > fault > stalk.
  - Hazard toggle-on from any state goes to `HAZARD`.
  - Hazard toggle-off goes to the stalk-resolved state: `FAULT` if `dL&dR`, else `LEFT` / `RIGHT` / `IDLE`. It never resolves to a comfort state.
  - `dL&dR` outside `HAZARD` goes to `FAULT`. `FAULT` exits to the stalk-resolved state when either contact releases.
  - `IDLE`: `dL` goes to `LEFT`; `dR` goes to `RIGHT`.
  - `LEFT`: `dL` falling with hold time < `TAP_CYCLES` goes to `LEFT_COMFORT`; hold time ≥ `TAP_CYCLES` goes to `IDLE`. `RIGHT` is symmetric.
  - `LEFT_COMFORT`:
    - `dL` returns to `LEFT` (hold timer restarts).
    - `dR` goes to `RIGHT` immediately.
    - Comfort timer expiry goes to `IDLE`.
    - `RIGHT_COMFORT` is symmetric.
- The hold timer counts cycles in `LEFT` / `RIGHT` and saturates at `TAP_CYCLES`.
- The comfort timer loads 0 on entry and expires when it reaches `COMFORT_CYCLES-1`.
- Both timers are one shared counter, sized `$clog2(max(TAP_CYCLES, COMFORT_CYCLES))+1`. Debounce counters are sized `$clog2(DEBOUNCE_CYCLES)+1`.
- The hazard state survives stalk activity. Stalk changes in `HAZARD` are tracked but produce no transition.

## Timing
- Reset (`nReset=0` at an edge) takes effect on that edge:
  - All outputs 0.
  - State `IDLE`.
  - Synchronizers, debounced values and counters 0.
- Reset mid-operation aborts comfort/hazard/fault immediately.
- Inputs held high through reset release re-debounce from 0:
  - A held stalk asserts its output `DEBOUNCE_CYCLES+3` cycles after release.
  - A held hazard button produces a rising edge and turns hazard on.
- Latency from a clean raw input transition to the output change is `DEBOUNCE_CYCLES+3` edges: 2 synchronizer, `DEBOUNCE_CYCLES` debounce, 1 output register.
- A bounce shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no output change.
- A simultaneous `dL` rise and `dR` rise in the same cycle goes to `FAULT`, never to `LEFT` or `RIGHT`.
- A hazard toggle in the same cycle as a fault condition goes to `HAZARD`.

## Configuration
- `TURN_SIGNAL_COMFORT_EN` defined:
  - Comfort states, tap detection and the shared timer are built as described above.
- `TURN_SIGNAL_COMFORT_EN` undefined:
  - No comfort states and no timer.
  - `LEFT`/`RIGHT` go to `IDLE` on release regardless of hold time.
  - `TAP_CYCLES` and `COMFORT_CYCLES` are ignored.

## Structure
- Package `turn_signal_pkg`:
  - State enum `ts_state_t`.
  - Default cycle constants for 50 MHz (10 ms, 0.5 s, 3 s).
- Sub-module `switch_debounce`, instantiated three times:
  - 2-FF synchronizer plus debounce counter.
  - Parameter `DEBOUNCE_CYCLES`.
  - Ports `c50M`, `nReset`, `raw`, `clean`, `rise` (one-cycle pulse).

## Test plan
- Use `DEBOUNCE_CYCLES=4`, `TAP_CYCLES=20`, `COMFORT_CYCLES=50`.
- Reset and bounce:
  - Reset → all outputs 0.
  - `rawLeft` toggles every 2 cycles for 20 cycles, then holds 1 → `leftBlink` rises exactly 7 cycles after the final edge, with no earlier glitch.
- Long hold: `rawLeft=1` for 40 cycles, then 0 → `leftBlink` falls 7 cycles after release; no comfort.
- Comfort tap:
  - `rawRight=1` for 10 cycles, then 0 → `rightBlink` stays 1 for 50 cycles after release is debounced, then falls.
  - A `rawLeft` press during comfort → `rightBlink=0` and `leftBlink=1` on the same edge.
- Fault and hazard:
  - `rawLeft`, `rawRight` rise together → `stalkFault=1`, both blink outputs 0.
  - A `rawHazard` pulse of 10 cycles → `hazardActive=1`, both blink outputs 1, `stalkFault=0`.
  - A second pulse → back to `FAULT` while both stalk contacts are still held.
- Reset mid-comfort: `nReset=0` for 1 cycle during `LEFT_COMFORT` → `leftBlink=0` on the next edge and stays 0.
- Build without `TURN_SIGNAL_COMFORT_EN`: the comfort-tap stimulus → `rightBlink` falls 7 cycles after release.

Source files
------------

// File: rtl/turn_signal_request_pkg.sv
// Shared types and 50 MHz defaults for the turn-signal request path.
// Comfort blinking is built only when TURN_SIGNAL_COMFORT_EN is defined.
package turn_signal_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;    // 10 ms
  localparam int DEFAULT_TAP_CYCLES      = 25000000;  // 0.5 s
  localparam int DEFAULT_COMFORT_CYCLES  = 150000000; // 3 s

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    LEFT          = 3'd1,
    RIGHT         = 3'd2,
    LEFT_COMFORT  = 3'd3,
    RIGHT_COMFORT = 3'd4,
    HAZARD        = 3'd5,
    FAULT         = 3'd6
  } ts_state_t;

  function automatic int maxInt(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // State implied by the stalk contacts alone, with no comfort extension.
  function automatic ts_state_t resolveStalk(logic dL, logic dR);
    if (dL && dR) begin
      return FAULT;
    end else if (dL) begin
      return LEFT;
    end else if (dR) begin
      return RIGHT;
    end else begin
      return IDLE;
    end
  endfunction

endpackage

// File: rtl/turn_signal_request_if.sv
// Stalk/hazard contacts in, blink request levels out.
interface turn_signal_request_if;
  logic rawLeft;
  logic rawRight;
  logic rawHazard;
  logic leftBlink;
  logic rightBlink;
  logic hazardActive;
  logic stalkFault;

  modport master (
    output rawLeft, rawRight, rawHazard,
    input  leftBlink, rightBlink, hazardActive, stalkFault
  );

  modport slave (
    input  rawLeft, rawRight, rawHazard,
    output leftBlink, rightBlink, hazardActive, stalkFault
  );
endinterface

// File: rtl/turn_signal_request_switch_debounce.sv
// Two-flop synchronizer followed by a stable-window debouncer for one contact.
module switch_debounce
  import turn_signal_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic c50M,
  input  logic nReset,
  input  logic raw,
  output logic clean,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

  logic             sync1_r;
  logic             sync2_r;
  logic             clean_r;
  logic             cleanDly_r;
  logic [CNT_W-1:0] cnt_r;

  // synchronize, then accept a change only once it has been stable long enough
  always_ff @(posedge c50M) begin
    if (!nReset) begin
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
      clean_r    <= 1'b0;
      cleanDly_r <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
    end else begin
      sync1_r    <= raw;
      sync2_r    <= sync1_r;
      cleanDly_r <= clean_r;
      if (sync2_r == clean_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        clean_r <= sync2_r;
        cnt_r   <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign clean = clean_r;
  // pulse is aligned with the first cycle the debounced level reads high
  assign rise  = clean_r & ~cleanDly_r;

endmodule

// File: rtl/turn_signal_request.sv
// Debounces stalk/hazard contacts and resolves them into blink request levels.
// Define TURN_SIGNAL_COMFORT_EN to build tap detection and comfort blinking.
module turn_signal_request
  import turn_signal_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int TAP_CYCLES      = DEFAULT_TAP_CYCLES,
  parameter int COMFORT_CYCLES  = DEFAULT_COMFORT_CYCLES
) (
  input logic                  c50M,
  input logic                  nReset,
  turn_signal_request_if.slave stalkIf
);

  logic      dL_s;
  logic      dR_s;
  logic      hazRise_s;
  logic      unusedLeftRise_s;
  logic      unusedRightRise_s;
  logic      unusedHazLevel_s;
  ts_state_t state_r;
  ts_state_t nextState_s;
  logic      leftBlink_r;
  logic      rightBlink_r;
  logic      hazardActive_r;
  logic      stalkFault_r;

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uLeft (
    .c50M(c50M), .nReset(nReset), .raw(stalkIf.rawLeft),
    .clean(dL_s), .rise(unusedLeftRise_s)
  );
  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uRight (
    .c50M(c50M), .nReset(nReset), .raw(stalkIf.rawRight),
    .clean(dR_s), .rise(unusedRightRise_s)
  );
  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uHazard (
    .c50M(c50M), .nReset(nReset), .raw(stalkIf.rawHazard),
    .clean(unusedHazLevel_s), .rise(hazRise_s)
  );

`ifdef TURN_SIGNAL_COMFORT_EN
  localparam int TMR_W = $clog2(maxInt(TAP_CYCLES, COMFORT_CYCLES)) + 1;

  logic [TMR_W-1:0] timer_r;
  logic             tapShort_s;
  logic             comfortDone_s;

  assign tapShort_s    = (timer_r < TMR_W'(TAP_CYCLES));
  assign comfortDone_s = (timer_r == TMR_W'(COMFORT_CYCLES - 1));

  // one counter serves as hold timer (saturating) and comfort timer; any state change restarts it
  always_ff @(posedge c50M) begin
    if (!nReset) begin
      timer_r <= {TMR_W{1'b0}};
    end else if (nextState_s != state_r) begin
      timer_r <= {TMR_W{1'b0}};
    end else if ((state_r == LEFT) || (state_r == RIGHT)) begin
      if (timer_r != TMR_W'(TAP_CYCLES)) begin
        timer_r <= timer_r + TMR_W'(1);
      end else begin
        timer_r <= timer_r;
      end
    end else if ((state_r == LEFT_COMFORT) || (state_r == RIGHT_COMFORT)) begin
      timer_r <= timer_r + TMR_W'(1);
    end else begin
      timer_r <= {TMR_W{1'b0}};
    end
  end
`else
  logic unusedTiming_s;
  assign unusedTiming_s = (TAP_CYCLES > 0) ^ (COMFORT_CYCLES > 0);
`endif

  // next state: hazard toggle beats fault, fault beats stalk handling
  always_comb begin
    nextState_s = state_r;
    if (hazRise_s) begin
      if (state_r == HAZARD) begin
        nextState_s = resolveStalk(dL_s, dR_s);
      end else begin
        nextState_s = HAZARD;
      end
    end else if (state_r == HAZARD) begin
      nextState_s = HAZARD;
    end else if (dL_s && dR_s) begin
      nextState_s = FAULT;
    end else begin
      case (state_r)
        IDLE:  nextState_s = resolveStalk(dL_s, dR_s);
        FAULT: nextState_s = resolveStalk(dL_s, dR_s);
`ifdef TURN_SIGNAL_COMFORT_EN
        LEFT: begin
          if (dL_s) begin
            nextState_s = LEFT;
          end else if (tapShort_s) begin
            nextState_s = LEFT_COMFORT;
          end else begin
            nextState_s = IDLE;
          end
        end
        RIGHT: begin
          if (dR_s) begin
            nextState_s = RIGHT;
          end else if (tapShort_s) begin
            nextState_s = RIGHT_COMFORT;
          end else begin
            nextState_s = IDLE;
          end
        end
        LEFT_COMFORT: begin
          if (dL_s || dR_s) begin
            nextState_s = resolveStalk(dL_s, dR_s);
          end else if (comfortDone_s) begin
            nextState_s = IDLE;
          end else begin
            nextState_s = LEFT_COMFORT;
          end
        end
        RIGHT_COMFORT: begin
          if (dL_s || dR_s) begin
            nextState_s = resolveStalk(dL_s, dR_s);
          end else if (comfortDone_s) begin
            nextState_s = IDLE;
          end else begin
            nextState_s = RIGHT_COMFORT;
          end
        end
`else
        LEFT:  nextState_s = dL_s ? LEFT : IDLE;
        RIGHT: nextState_s = dR_s ? RIGHT : IDLE;
`endif
        default: nextState_s = IDLE;
      endcase
    end
  end

  // outputs are registered from the state being entered so they change with it
  always_ff @(posedge c50M) begin
    if (!nReset) begin
      state_r        <= IDLE;
      leftBlink_r    <= 1'b0;
      rightBlink_r   <= 1'b0;
      hazardActive_r <= 1'b0;
      stalkFault_r   <= 1'b0;
    end else begin
      state_r        <= nextState_s;
      leftBlink_r    <= (nextState_s == LEFT) || (nextState_s == LEFT_COMFORT) ||
                        (nextState_s == HAZARD);
      rightBlink_r   <= (nextState_s == RIGHT) || (nextState_s == RIGHT_COMFORT) ||
                        (nextState_s == HAZARD);
      hazardActive_r <= (nextState_s == HAZARD);
      stalkFault_r   <= (nextState_s == FAULT);
    end
  end

  assign stalkIf.leftBlink    = leftBlink_r;
  assign stalkIf.rightBlink   = rightBlink_r;
  assign stalkIf.hazardActive = hazardActive_r;
  assign stalkIf.stalkFault   = stalkFault_r;

endmodule

// File: tb/tb_turn_signal_request.sv
// Directed bench: stimulus queues expected output events, a monitor checks them.
module tb_turn_signal_request;

  logic c50M = 1'b0;
  logic nReset;

  turn_signal_request_if sig();

  turn_signal_request #(
    .DEBOUNCE_CYCLES(4),
    .TAP_CYCLES(20),
    .COMFORT_CYCLES(50)
  ) dut (
    .c50M(c50M),
    .nReset(nReset),
    .stalkIf(sig.slave)
  );

  always #5 c50M = ~c50M;

  // expected output vector {leftBlink, rightBlink, hazardActive, stalkFault} at a cycle
  typedef struct {
    int         cyc;
    logic [3:0] val;
  } exp_t;

  exp_t       expQ[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  bit         monEn = 1'b0;
  logic [3:0] prev = 4'b0000;
  logic [3:0] monCur;
  exp_t       monE;

  always @(posedge c50M) cyc <= cyc + 1;

  task automatic expectAt(input int c, input logic [3:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    expQ.push_back(e);
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge c50M);
  endtask

  // monitor: every output change must match the queue head; due entries also checked as levels
  always @(negedge c50M) begin
    monCur = {sig.leftBlink, sig.rightBlink, sig.hazardActive, sig.stalkFault};
    if (monEn) begin
      if (monCur !== prev) begin
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, monCur);
        end else begin
          monE = expQ.pop_front();
          if ((monE.cyc != cyc) || (monE.val !== monCur)) begin
            bad++;
            $display("FAIL out_change cyc=%0d got=%b required cyc=%0d val=%b",
                     cyc, monCur, monE.cyc, monE.val);
          end
        end
      end else if ((expQ.size() != 0) && (expQ[0].cyc <= cyc)) begin
        total++;
        monE = expQ.pop_front();
        if ((monE.cyc != cyc) || (monE.val !== monCur)) begin
          bad++;
          $display("FAIL out_level cyc=%0d got=%b required cyc=%0d val=%b",
                   cyc, monCur, monE.cyc, monE.val);
        end
      end
      prev = monCur;
    end
  end

  int base, f, a, b, c, r;

  initial begin
    nReset        = 1'b0;
    sig.rawLeft   = 1'b0;
    sig.rawRight  = 1'b0;
    sig.rawHazard = 1'b0;
    repeat (3) @(negedge c50M);
    monEn = 1'b1;
    expectAt(cyc + 1, 4'b0000);
    @(negedge c50M);
    nReset = 1'b1;
    expectAt(cyc + 5, 4'b0000);

    // bounce then settle high: left request 7 cycles after the final edge
    base = cyc + 8;
    waitUntil(base);
    for (int i = 0; i < 10; i++) begin
      sig.rawLeft = ((i % 2) == 0);
      repeat (2) @(negedge c50M);
    end
    sig.rawLeft = 1'b1;
    f = cyc;
    expectAt(f + 7, 4'b1000);

    // long hold: plain release, no comfort
    waitUntil(f + 40);
    sig.rawLeft = 1'b0;
    expectAt(f + 47, 4'b0000);
    expectAt(f + 70, 4'b0000);

    // right tap runs to comfort expiry
    a = f + 80;
    waitUntil(a);
    sig.rawRight = 1'b1;
    expectAt(a + 7, 4'b0100);
    waitUntil(a + 10);
    sig.rawRight = 1'b0;
`ifdef TURN_SIGNAL_COMFORT_EN
    expectAt(a + 40, 4'b0100);
    expectAt(a + 67, 4'b0000);
`else
    expectAt(a + 17, 4'b0000);
    expectAt(a + 40, 4'b0000);
`endif

    // right tap, left press during comfort, left tap, then reset mid-comfort
    b = a + 90;
    waitUntil(b);
    sig.rawRight = 1'b1;
    expectAt(b + 7, 4'b0100);
    waitUntil(b + 10);
    sig.rawRight = 1'b0;
`ifndef TURN_SIGNAL_COMFORT_EN
    expectAt(b + 17, 4'b0000);
`endif
    waitUntil(b + 20);
    sig.rawLeft = 1'b1;
    expectAt(b + 27, 4'b1000);
    waitUntil(b + 30);
    sig.rawLeft = 1'b0;
`ifndef TURN_SIGNAL_COMFORT_EN
    expectAt(b + 37, 4'b0000);
`endif
    waitUntil(b + 45);
    nReset = 1'b0;
    expectAt(b + 46, 4'b0000);
    @(negedge c50M);
    nReset = 1'b1;
    expectAt(b + 60, 4'b0000);
    expectAt(b + 80, 4'b0000);

    // fault, hazard over fault, hazard off back to fault, release
    c = b + 90;
    waitUntil(c);
    sig.rawLeft  = 1'b1;
    sig.rawRight = 1'b1;
    expectAt(c + 7, 4'b0001);
    waitUntil(c + 15);
    sig.rawHazard = 1'b1;
    expectAt(c + 22, 4'b1110);
    waitUntil(c + 25);
    sig.rawHazard = 1'b0;
    waitUntil(c + 35);
    sig.rawHazard = 1'b1;
    expectAt(c + 42, 4'b0001);
    waitUntil(c + 45);
    sig.rawHazard = 1'b0;
    waitUntil(c + 55);
    sig.rawLeft  = 1'b0;
    sig.rawRight = 1'b0;
    expectAt(c + 62, 4'b0000);

    // inputs held through reset: hazard wins over the stalk, survives its release
    waitUntil(c + 80);
    nReset        = 1'b0;
    sig.rawRight  = 1'b1;
    sig.rawHazard = 1'b1;
    repeat (3) @(negedge c50M);
    nReset = 1'b1;
    r = cyc;
    expectAt(r + 7, 4'b1110);
    waitUntil(r + 10);
    sig.rawHazard = 1'b0;
    waitUntil(r + 12);
    sig.rawRight = 1'b0;
    expectAt(r + 25, 4'b1110);
    waitUntil(r + 30);
    sig.rawHazard = 1'b1;
    expectAt(r + 37, 4'b0000);
    waitUntil(r + 40);
    sig.rawHazard = 1'b0;

    waitUntil(r + 60);
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0 first_cyc=%0d", expQ.size(), expQ[0].cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
